// File: rtl/mig_seq_eval.sv
// mig_seq_eval: programmable majority-inverter-graph evaluator.
// A node program is loaded while idle; each accepted vector is then evaluated one MIG node per cycle.
module mig_seq_eval #(
    parameter int NUM_IN    = 7,
    parameter int MAX_NODES = 16,
    parameter int NODE_W    = $clog2(MAX_NODES),
    parameter int SEL_W     = $clog2(1 + NUM_IN + MAX_NODES),
    parameter int OP_W      = SEL_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [NODE_W-1:0] cfg_addr,
    input  logic [3*OP_W-1:0] cfg_data,
    input  logic [NODE_W:0]   num_nodes,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_IN-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic              out_err,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Valid/ready: a transfer occurs on a rising edge where valid and ready are both high;
    // the sender holds valid and payload until then, and ready is a pure function of FSM state.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] NODE_BASE = SEL_W'(NUM_IN + 1);
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_IN + MAX_NODES);

    state_t                state;
    state_t                state_next;
    logic [3*OP_W-1:0]     prog [MAX_NODES];
    logic [MAX_NODES-1:0]  res;
    logic [NUM_IN-1:0]     x_q;
    logic [NODE_W:0]       nn_q;
    logic [NODE_W-1:0]     k;
    logic                  y_q;
    logic                  err_q;

    logic [3*OP_W-1:0]     entry;
    logic [1:0]            dec_a;
    logic [1:0]            dec_b;
    logic [1:0]            dec_c;
    logic                  op_err;
    logic                  node_val;
    logic                  last;
    logic                  cfg_err;
    logic [NODE_W:0]       k_plus;

    // Returns {error, operand value}; a node operand is legal only if it refers to an earlier node.
    function automatic logic [1:0] decode_op(
        input logic [OP_W-1:0]      op,
        input logic [NUM_IN-1:0]    x,
        input logic [MAX_NODES-1:0] r,
        input logic [NODE_W-1:0]    kk
    );
        logic [SEL_W-1:0] sel;
        logic [SEL_W-1:0] j;
        logic             v;
        logic             e;
        sel = op[SEL_W-1:0];
        j   = sel - NODE_BASE;
        v   = 1'b0;
        e   = 1'b0;
        if (sel == '0) begin
            v = 1'b0;
        end else if (sel < NODE_BASE) begin
            v = |(x & (NUM_IN'(1) << (sel - SEL_W'(1))));
        end else if (sel <= SEL_MAX) begin
            if (j >= SEL_W'(kk)) e = 1'b1;
            else                 v = |(r & (MAX_NODES'(1) << j));
        end else begin
            e = 1'b1;
        end
        return {e, v ^ op[OP_W-1]};
    endfunction

    always_comb begin
        entry = prog[k];
        dec_a = decode_op(entry[OP_W-1:0],        x_q, res, k);
        dec_b = decode_op(entry[2*OP_W-1:OP_W],   x_q, res, k);
        dec_c = decode_op(entry[3*OP_W-1:2*OP_W], x_q, res, k);
    end

    assign op_err   = dec_a[1] | dec_b[1] | dec_c[1];
    assign node_val = (dec_a[0] & dec_b[0]) | (dec_a[0] & dec_c[0]) | (dec_b[0] & dec_c[0]);
    assign k_plus   = {1'b0, k} + (NODE_W+1)'(1);
    assign last     = (k_plus == nn_q);
    assign cfg_err  = (num_nodes == '0) || (num_nodes > (NODE_W+1)'(MAX_NODES));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid) state_next = cfg_err ? S_DONE : S_EVAL;
            S_EVAL: if (op_err || last) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            for (int i = 0; i < MAX_NODES; i++) prog[i] <= '0;
            res   <= '0;
            x_q   <= '0;
            nn_q  <= '0;
            k     <= '0;
            y_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (cfg_we) prog[cfg_addr] <= cfg_data;
                    if (in_valid) begin
                        x_q   <= in_x;
                        nn_q  <= num_nodes;
                        k     <= '0;
                        y_q   <= 1'b0;
                        err_q <= cfg_err;
                    end
                end
                S_EVAL: begin
                    if (op_err) begin
                        err_q <= 1'b1;
                        y_q   <= 1'b0;
                    end else begin
                        res[k] <= node_val;
                        if (last) y_q <= node_val;
                        else      k   <= k + NODE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_y     = y_q;
    assign out_err   = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mig_seq_eval.sv
// Testbench for mig_seq_eval: feature tasks with a result queue fed at stimulus time
// and drained as results appear.
module tb_mig_seq_eval;

    localparam int NUM_IN    = 7;
    localparam int MAX_NODES = 16;
    localparam int OP_W      = 6;
    localparam logic [5:0] C0  = 6'h00;  // constant 0
    localparam logic [5:0] NC0 = 6'h20;  // inverted constant 0

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [17:0] cfg_data;
    logic [4:0]  num_nodes;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_x;
    logic        out_valid;
    logic        out_ready;
    logic        out_y;
    logic        out_err;
    logic        busy;
    logic [1:0]  dbg_state;

    mig_seq_eval dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .num_nodes(num_nodes), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  exp_q[$];          // {err, y}
    logic [17:0] sw_prog [16];

    function automatic logic [5:0] xo(input int i);
        return 6'(i + 1);
    endfunction

    function automatic logic [5:0] nd(input int j);
        return 6'(NUM_IN + 1 + j);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic ref6(input logic [6:0] x);
        logic n0, n1, n2, n3, n4;
        n0 = maj3(x[0], x[1], x[3]);
        n1 = maj3(x[0], x[1], x[2]);
        n2 = maj3(x[2], x[4], n0);
        n3 = maj3(x[5], n1, n2);
        n4 = maj3(x[1], x[3], x[6]);
        return maj3(x[0], n3, n4);
    endfunction

    function automatic logic [1:0] model(input logic [6:0] x, input int nn);
        logic [15:0] r;
        logic [15:0] tr;
        logic [6:0]  tx;
        logic [5:0]  op;
        logic [2:0]  v;
        logic        b;
        int          s;
        r = '0;
        if (nn < 1 || nn > MAX_NODES) return 2'b10;
        for (int kk = 0; kk < nn; kk++) begin
            v = '0;
            for (int i = 0; i < 3; i++) begin
                op = sw_prog[kk][i*OP_W +: OP_W];
                s  = int'(op[4:0]);
                b  = 1'b0;
                if (s == 0) begin
                    b = 1'b0;
                end else if (s <= NUM_IN) begin
                    tx = x >> (s - 1);
                    b  = tx[0];
                end else if (s <= NUM_IN + MAX_NODES) begin
                    if (s - NUM_IN - 1 >= kk) return 2'b10;
                    tr = r >> (s - NUM_IN - 1);
                    b  = tr[0];
                end else begin
                    return 2'b10;
                end
                v = {v[1:0], b ^ op[5]};
            end
            r = r | (16'(maj3(v[0], v[1], v[2])) << kk);
        end
        tr = r >> (nn - 1);
        return {1'b0, tr[0]};
    endfunction

    task automatic load_node(input int addr, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        cfg_we   = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = {c, b, a};
        sw_prog[addr] = {c, b, a};
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_prog6();
        load_node(0, xo(0), xo(1), xo(3));
        load_node(1, xo(0), xo(1), xo(2));
        load_node(2, xo(2), xo(4), nd(0));
        load_node(3, xo(5), nd(1), nd(2));
        load_node(4, xo(1), xo(3), xo(6));
        load_node(5, xo(0), nd(3), nd(4));
    endtask

    // Called at a negedge; returns at the negedge just after the acceptance edge.
    task automatic send(input logic [6:0] x, input int nn, output bit ok);
        int guard;
        guard     = 0;
        in_x      = x;
        num_nodes = 5'(nn);
        in_valid  = 1'b1;
        while (!in_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // lat counts the acceptance cycle as 1.
    task automatic wait_out(output int lat, output bit seen);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        seen = out_valid;
    endtask

    task automatic test_reset();
        int lat; bit ok, seen; logic [1:0] e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_y !== 1'b0) begin n_fail++; $display("FAIL rst_out_y: got %b want 0", out_y); end
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err: got %b want 0", out_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(model(7'h55, 1));
        send(7'h55, 1, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (!ok || !seen) begin n_fail++; $display("FAIL rst_eval_handshake: accepted %b result %b want 1 1", ok, seen); end
        n_checks++; if (out_y !== e[0] || out_y !== 1'b0) begin n_fail++; $display("FAIL rst_default_prog: got %b want 0", out_y); end
        @(negedge clk);
    endtask

    task automatic test_program6();
        int lat; bit ok, seen; logic [1:0] e;
        load_prog6();
        exp_q.push_back(model(7'h7F, 6));
        send(7'h7F, 6, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (!ok || !seen) begin n_fail++; $display("FAIL p6_handshake: accepted %b result %b want 1 1", ok, seen); end
        n_checks++; if (lat != 7) begin n_fail++; $display("FAIL p6_latency: got %0d want 7", lat); end
        n_checks++; if (out_y !== e[0] || out_y !== 1'b1) begin n_fail++; $display("FAIL p6_y_7f: got %b want 1", out_y); end
        n_checks++; if (out_err !== e[1]) begin n_fail++; $display("FAIL p6_err_7f: got %b want %b", out_err, e[1]); end
        @(negedge clk);
        exp_q.push_back(model(7'h00, 6));
        send(7'h00, 6, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || out_y !== e[0] || out_y !== 1'b0) begin n_fail++; $display("FAIL p6_y_00: got %b valid %b want 0", out_y, seen); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int got, last_cyc, guard, n_rej;
        logic [1:0] e;
        got = 0; last_cyc = -1; n_rej = 0;
        fork
            begin
                for (int v = 0; v < 128; v++) begin
                    bit ok;
                    exp_q.push_back({1'b0, ref6(7'(v))});
                    send(7'(v), 6, ok);
                    if (!ok) n_rej++;
                end
            end
            begin
                guard = 0;
                while (got < 128 && guard < 128 * 8 + 100) begin
                    @(negedge clk);
                    guard++;
                    if (out_valid) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++; $display("FAIL b2b_extra: unexpected result y=%b", out_y);
                        end else begin
                            e = exp_q.pop_front();
                            if (out_y !== e[0] || out_err !== e[1]) begin
                                n_fail++; $display("FAIL b2b_result %0d: got y=%b err=%b want y=%b err=%b", got, out_y, out_err, e[0], e[1]);
                            end
                        end
                        if (last_cyc >= 0) begin
                            n_checks++;
                            if (cyc - last_cyc != 8) begin n_fail++; $display("FAIL b2b_period %0d: got %0d want 8", got, cyc - last_cyc); end
                        end
                        last_cyc = cyc;
                        got++;
                    end
                end
            end
        join
        n_checks++; if (got != 128 || n_rej != 0) begin n_fail++; $display("FAIL b2b_count: got %0d results %0d rejects want 128 0", got, n_rej); end
        @(negedge clk);
    endtask

    task automatic test_inv_const();
        int lat; bit ok, seen; logic [1:0] e; logic [6:0] x;
        load_node(0, C0, C0, C0);
        for (int t = 0; t < 2; t++) begin
            x = 7'($urandom_range(0, 127));
            x[0] = t[0];
            if (t == 0) begin
                // write and acceptance on the same edge: the new entry must be used
                cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = {C0, xo(0), NC0};
                sw_prog[0] = {C0, xo(0), NC0};
            end
            exp_q.push_back(model(x, 1));
            send(x, 1, ok);
            cfg_we = 1'b0;
            wait_out(lat, seen);
            e = exp_q.pop_front();
            n_checks++; if (lat != 2 || !ok) begin n_fail++; $display("FAIL inv_latency: got %0d want 2", lat); end
            n_checks++; if (out_y !== e[0] || out_y !== x[0]) begin n_fail++; $display("FAIL inv_y x=%h: got %b want %b", x, out_y, x[0]); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit ok, seen; logic [1:0] e; logic [6:0] x;
        x = 7'($urandom_range(0, 127)) | 7'h01;
        out_ready = 1'b0;
        exp_q.push_back(model(x, 1));
        send(x, 1, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_y !== e[0] || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold %0d: valid=%b y=%b in_ready=%b want 1 %b 0", i, out_valid, out_y, in_ready, e[0]);
            end
            cfg_we = (i == 1); cfg_addr = 4'd0; cfg_data = '0;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_path: got %b want 0", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
        exp_q.push_back(model(x, 1));
        send(x, 1, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || out_y !== e[0] || out_y !== 1'b1) begin n_fail++; $display("FAIL bp_old_prog: got %b want 1", out_y); end
        @(negedge clk);
    endtask

    task automatic test_errors();
        int lat; bit ok, seen; logic [1:0] e;
        exp_q.push_back(model(7'h7F, 0));
        send(7'h7F, 0, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL err_nn0_latency: got %0d want 1", lat); end
        n_checks++; if (out_err !== e[1] || out_err !== 1'b1 || out_y !== 1'b0) begin n_fail++; $display("FAIL err_nn0: err=%b y=%b want 1 0", out_err, out_y); end
        @(negedge clk);
        exp_q.push_back(model(7'h7F, 17));
        send(7'h7F, 17, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (out_err !== e[1] || out_err !== 1'b1) begin n_fail++; $display("FAIL err_nn17: got %b want 1", out_err); end
        @(negedge clk);
        load_node(0, xo(0), xo(1), xo(2));
        load_node(1, xo(3), xo(4), xo(5));
        load_node(2, xo(0), nd(3), xo(1));
        load_node(3, xo(6), xo(6), xo(6));
        exp_q.push_back(model(7'h7F, 4));
        send(7'h7F, 4, ok);
        n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_accept: got %b want 0", out_err); end
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || out_err !== e[1] || out_err !== 1'b1 || out_y !== 1'b0) begin n_fail++; $display("FAIL err_fwd_ref: err=%b y=%b want 1 0", out_err, out_y); end
        @(negedge clk);
        load_node(0, 6'd31, xo(0), xo(1));
        exp_q.push_back(model(7'h7F, 1));
        send(7'h7F, 1, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (out_err !== e[1] || out_err !== 1'b1) begin n_fail++; $display("FAIL err_sel_range: got %b want 1", out_err); end
        @(negedge clk);
        load_node(0, xo(0), xo(1), xo(2));
        exp_q.push_back(model(7'h7F, 1));
        send(7'h7F, 1, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (out_err !== e[1] || out_err !== 1'b0 || out_y !== 1'b1) begin n_fail++; $display("FAIL err_recover: err=%b y=%b want 0 1", out_err, out_y); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; bit ok, seen; logic [1:0] e; logic [6:0] x;
        load_prog6();
        send(7'h7F, 6, ok);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_y !== 1'b0 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: rdy=%b vld=%b busy=%b y=%b err=%b want 1 0 0 0 0", in_ready, out_valid, busy, out_y, out_err);
        end
        for (int i = 0; i < 16; i++) sw_prog[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(model(7'h7F, 6));
        send(7'h7F, 6, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || out_y !== e[0] || out_y !== 1'b0) begin n_fail++; $display("FAIL mid_prog_cleared: got %b want 0", out_y); end
        @(negedge clk);
        x = 7'($urandom_range(0, 127));
        exp_q.push_back(model(x, 1));
        send(x, 1, ok);
        wait_out(lat, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || out_y !== e[0] || out_y !== 1'b0) begin n_fail++; $display("FAIL mid_node0_cleared: got %b want 0", out_y); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) sw_prog[i] = '0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        num_nodes = '0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        test_reset();
        test_program6();
        test_back_to_back();
        test_inv_const();
        test_backpressure();
        test_errors();
        test_reset_mid();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_drain: %0d results never arrived", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mig_seq_eval.md
Name: mig_seq_eval

Overview:
Programmable sequential majority-inverter-graph (MIG) evaluator. It generalises our fixed 7-input majority networks into one engine: a node program is loaded once, then input vectors are evaluated one MIG node per cycle. Valid/ready handshakes on both input and output let it sit behind a vector source in function-classification and equivalence-check benches.

Parameters:
NUM_IN, 7, number of primary inputs x[NUM_IN-1:0]
MAX_NODES, 16, program memory depth (maximum MIG nodes)
NODE_W, clog2(MAX_NODES), node index width
SEL_W, clog2(1+NUM_IN+MAX_NODES), operand selector width (5 at defaults)
OP_W, SEL_W+1, operand field = {inv, sel}

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  program write strobe; honoured only in IDLE
cfg_addr  in  NODE_W  node index written
cfg_data  in  3*OP_W  {opC, opB, opA}, opA in LSBs
num_nodes  in  NODE_W+1  node count for this evaluation; sampled at input acceptance
in_valid  in  1  input vector valid
in_ready  out  1  engine can accept a vector
in_x  in  NUM_IN  primary input vector
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_y  out  1  evaluated function value (last node)
out_err  out  1  program error flag, qualified by out_valid
busy  out  1  high in EVAL or DONE

Behaviour:
- Operand decode: sel=0 -> constant 0; sel=1..NUM_IN -> in_x[sel-1]; sel=NUM_IN+1+j -> node result j. inv=1 complements the operand.
- Node k = MAJ(A,B,C) = AB|AC|BC over the decoded operands.
- Reset: state=IDLE; in_ready=1; out_valid=0; out_y=0; out_err=0; busy=0; all program entries=0, so every node is MAJ(0,0,0)=0; node result regs=0.
- FSM IDLE:
  - in_ready=1.
  - A cfg_we write updates the program entry in the same cycle.
  - If cfg_we and in_valid occur together, both happen; the evaluation uses the new entry.
  - On in_valid&in_ready: latch in_x and num_nodes, set k=0, go to EVAL.
- FSM EVAL:
  - in_ready=0; cfg_we is ignored.
  - Each cycle computes node k and writes it to result reg k.
  - If k==num_nodes-1: out_y=node k, go to DONE.
  - Otherwise k increments.
- Latency: out_valid rises num_nodes+1 cycles after the acceptance edge. Throughput is one vector per num_nodes+2 cycles when out_ready is held high.
- FSM DONE:
  - out_valid=1; out_y and out_err are held stable until out_ready.
  - On out_valid&out_ready: out_valid=0, go to IDLE, in_ready returns the next cycle.
  - No combinational path from out_ready to in_ready.
- Errors (out_err=1, out_y=0, go straight to DONE):
  - Checked at acceptance: num_nodes==0 or num_nodes>MAX_NODES.
  - Checked in EVAL: an operand selects a node j>=k (forward or self reference), or sel>NUM_IN+MAX_NODES.
  - out_err clears when the next vector is accepted.
- in_valid while in_ready=0 is held by the source; the engine does not sample it.
- Reset mid-operation returns all state to reset values, including the program memory.

Test Plan:
- Load a 6-node program: n0=MAJ(x0,x1,x3), n1=MAJ(x0,x1,x2), n2=MAJ(x2,x4,n0), n3=MAJ(x5,n1,n2), n4=MAJ(x1,x3,x6), n5=MAJ(x0,n3,n4); num_nodes=6. Apply in_x=7'h7F -> out_y=1, out_err=0, out_valid exactly 7 cycles after acceptance. Apply in_x=7'h00 -> out_y=0.
- Same program, all 128 vectors back-to-back with out_ready=1 -> every out_y matches the software MIG model; one result per 8 cycles.
- Inverter/constant check: single node MAJ(~const0, x0, const0), num_nodes=1 -> out_y=x0, latency 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_y stay stable, in_ready=0, a cfg_we write is ignored (readback via a follow-up evaluation shows the old program).
- Errors: num_nodes=0 -> out_err=1 on the cycle after acceptance. Node 2 referencing node 3 -> out_err=1, out_y=0. The next valid evaluation clears out_err.
- Assert rst_n low during EVAL -> outputs return to reset values immediately. The previously loaded program now evaluates to 0 for any vector.
